// File: rtl/cpu_loader_pkg.sv
// Shared types for the CPU program loader: FSM state encoding and the
// word-index to byte-address shift used on both memory ports.
package cpu_loader_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD_I    = 4'd1,
    HDR_M     = 4'd2,
    LOAD_D    = 4'd3,
    HDR_C     = 4'd4,
    HDR_D     = 4'd5,
    RUN       = 4'd6,
    DUMP_RD   = 4'd7,
    DUMP_WAIT = 4'd8,
    DUMP_OUT  = 4'd9,
    ERR       = 4'd10
  } loader_state_t;

  localparam int ADDR_SHIFT = 2;

endpackage

// File: rtl/cpu_prog_loader.sv
// Boot front-end: loads imem/dmem from a word stream, runs the CPU for C
// cycles, then streams a window of dmem back out.
module cpu_prog_loader
  import cpu_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic        cpu_enable,
  output logic [31:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic        dmem_ren,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int IW = $clog2(IMEM_DEPTH) + 1;
  localparam int DW = $clog2(DMEM_DEPTH) + 1;

  loader_state_t    state_r, state_s;
  logic [IW-1:0]    n_r, n_s, iidx_r, iidx_s;
  logic [DW-1:0]    m_r, m_s, didx_r, didx_s;
  logic [DW-1:0]    d_r, d_s, k_r, k_s;
  logic [CNT_W-1:0] c_r, c_s, run_cnt_r, run_cnt_s;
  logic [31:0]      m_data_r, m_data_s;
  logic             xfer_s;

  // Input handshake; gated by reset so nothing is accepted while it is held.
  always_comb begin
    s_ready = 1'b0;
    case (state_r)
      IDLE, LOAD_I, HDR_M, LOAD_D, HDR_C, HDR_D: s_ready = arst_n;
      default:                                   s_ready = 1'b0;
    endcase
  end

  assign xfer_s     = s_valid && s_ready;
  assign m_valid    = (state_r == DUMP_OUT);
  assign m_data     = m_data_r;
  assign busy       = (state_r != IDLE) && (state_r != ERR);
  assign error      = (state_r == ERR);

  // Next-state, counter updates and memory-port strobes.
  always_comb begin
    state_s    = state_r;
    n_s        = n_r;
    m_s        = m_r;
    d_s        = d_r;
    c_s        = c_r;
    iidx_s     = iidx_r;
    didx_s     = didx_r;
    k_s        = k_r;
    run_cnt_s  = run_cnt_r;
    m_data_s   = m_data_r;
    imem_wen   = 1'b0;
    imem_addr  = 32'd0;
    imem_wdata = 32'd0;
    dmem_wen   = 1'b0;
    dmem_ren   = 1'b0;
    dmem_addr  = 32'd0;
    dmem_wdata = 32'd0;
    cpu_enable = 1'b0;
    done       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!xfer_s) begin
          state_s = IDLE;
        end else if (s_data == 32'd0 || s_data > 32'(IMEM_DEPTH)) begin
          state_s = ERR;
        end else begin
          n_s     = s_data[IW-1:0];
          iidx_s  = '0;
          state_s = LOAD_I;
        end
      end
      LOAD_I: begin
        if (xfer_s) begin
          imem_wen   = 1'b1;
          imem_addr  = {{(32-IW){1'b0}}, iidx_r} << ADDR_SHIFT;
          imem_wdata = s_data;
          iidx_s     = iidx_r + IW'(1);
          state_s    = (iidx_r == n_r - IW'(1)) ? HDR_M : LOAD_I;
        end else begin
          state_s = LOAD_I;
        end
      end
      HDR_M: begin
        if (!xfer_s) begin
          state_s = HDR_M;
        end else if (s_data > 32'(DMEM_DEPTH)) begin
          state_s = ERR;
        end else begin
          m_s     = s_data[DW-1:0];
          didx_s  = '0;
          state_s = (s_data == 32'd0) ? HDR_C : LOAD_D;
        end
      end
      LOAD_D: begin
        if (xfer_s) begin
          dmem_wen   = 1'b1;
          dmem_addr  = {{(32-DW){1'b0}}, didx_r} << ADDR_SHIFT;
          dmem_wdata = s_data;
          didx_s     = didx_r + DW'(1);
          state_s    = (didx_r == m_r - DW'(1)) ? HDR_C : LOAD_D;
        end else begin
          state_s = LOAD_D;
        end
      end
      HDR_C: begin
        if (xfer_s) begin
          c_s     = CNT_W'(s_data);
          state_s = HDR_D;
        end else begin
          state_s = HDR_C;
        end
      end
      HDR_D: begin
        if (!xfer_s) begin
          state_s = HDR_D;
        end else if (s_data > 32'(DMEM_DEPTH)) begin
          state_s = ERR;
        end else begin
          d_s       = s_data[DW-1:0];
          run_cnt_s = '0;
          k_s       = '0;
          // C==0 bypasses RUN entirely so the CPU never sees an enable cycle.
          if (c_r != '0) begin
            state_s = RUN;
          end else if (s_data != 32'd0) begin
            state_s = DUMP_RD;
          end else begin
            state_s = IDLE;
            done    = 1'b1;
          end
        end
      end
      RUN: begin
        cpu_enable = 1'b1;
        run_cnt_s  = run_cnt_r + CNT_W'(1);
        if (run_cnt_r != c_r - CNT_W'(1)) begin
          state_s = RUN;
        end else if (d_r != '0) begin
          state_s = DUMP_RD;
        end else begin
          state_s = IDLE;
          done    = 1'b1;
        end
      end
      DUMP_RD: begin
        dmem_ren  = 1'b1;
        dmem_addr = {{(32-DW){1'b0}}, k_r} << ADDR_SHIFT;
        state_s   = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        m_data_s = dmem_rdata;
        state_s  = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (!m_ready) begin
          state_s = DUMP_OUT;
        end else if (k_r + DW'(1) == d_r) begin
          k_s     = k_r + DW'(1);
          state_s = IDLE;
          done    = 1'b1;
        end else begin
          k_s     = k_r + DW'(1);
          state_s = DUMP_RD;
        end
      end
      ERR:     state_s = ERR;
      default: state_s = ERR;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_r   <= IDLE;
      n_r       <= '0;
      m_r       <= '0;
      d_r       <= '0;
      c_r       <= '0;
      iidx_r    <= '0;
      didx_r    <= '0;
      k_r       <= '0;
      run_cnt_r <= '0;
      m_data_r  <= 32'd0;
    end else begin
      state_r   <= state_s;
      n_r       <= n_s;
      m_r       <= m_s;
      d_r       <= d_s;
      c_r       <= c_s;
      iidx_r    <= iidx_s;
      didx_r    <= didx_s;
      k_r       <= k_s;
      run_cnt_r <= run_cnt_s;
      m_data_r  <= m_data_s;
    end
  end

endmodule
